// File: rtl/useq_pkg.sv
// Shared opcodes, microword layout helpers and width functions for the useq microcode sequencer.
package useq_pkg;

  localparam logic [2:0] OP_SEQ  = 3'd0;
  localparam logic [2:0] OP_DISP = 3'd1;
  localparam logic [2:0] OP_JMP  = 3'd2;
  localparam logic [2:0] OP_HOLD = 3'd3;
  localparam logic [2:0] OP_ZERO = 3'd4;
  localparam logic [2:0] OP_CALL = 3'd5;
  localparam logic [2:0] OP_RET  = 3'd6;
  localparam logic [2:0] OP_BRY  = 3'd7;

  localparam int unsigned TGT_LSB = 0;

  // Table-select width never drops below one bit, even with a single dispatch table.
  function automatic int unsigned ts_w(input int unsigned ndisp);
    return (ndisp > 1) ? $clog2(ndisp) : 1;
  endfunction

  function automatic int unsigned addr_w(input int unsigned state_w, input int unsigned ndisp,
                                         input int unsigned y_w);
    return state_w + ts_w(ndisp) + y_w;
  endfunction

  function automatic int unsigned word_w(input int unsigned state_w, input int unsigned ndisp);
    return 3 + ts_w(ndisp) + state_w;
  endfunction

  function automatic int unsigned tsel_lsb(input int unsigned state_w);
    return state_w;
  endfunction

  function automatic int unsigned op_lsb(input int unsigned state_w, input int unsigned ndisp);
    return state_w + ts_w(ndisp);
  endfunction

endpackage

// File: rtl/useq_stack.sv
// Return-address LIFO for the useq sequencer; pushes when full and pops when empty are dropped.
module useq_stack #(
  parameter int unsigned W = 4,
  parameter int unsigned D = 2,
  localparam int unsigned LW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  top_o,
  output logic [LW-1:0] lvl_o,
  output logic          ovf_o,
  output logic          unf_o
);

  localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  mem_q [D];
  logic [LW-1:0] lvl_q, lvl_d;
  logic [IW-1:0] wr_idx, rd_idx;
  logic          full, empty;

  assign full   = (lvl_q == LW'(D));
  assign empty  = (lvl_q == '0);
  assign wr_idx = IW'(lvl_q);
  assign rd_idx = IW'(lvl_q - LW'(1));

  always_comb begin
    lvl_d = lvl_q;
    if (push_i && !full) begin
      lvl_d = lvl_q + LW'(1);
    end else if (pop_i && !empty) begin
      lvl_d = lvl_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= '0;
    end else begin
      lvl_q <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full) begin
      mem_q[wr_idx] <= data_i;
    end
  end

  // ovf/unf mark the levels at which a push/pop would be dropped.
  assign top_o = mem_q[rd_idx];
  assign lvl_o = lvl_q;
  assign ovf_o = full;
  assign unf_o = empty;

endmodule

// File: rtl/useq_fsm.sv
// Programmable microcode sequencer: writable microword ROM and dispatch tables, call stack and a
// sticky error flag for out-of-range targets and stack faults.
module useq_fsm
  import useq_pkg::*;
#(
  parameter int unsigned STATE_W = 4,
  parameter int unsigned DEPTH   = 13,
  parameter int unsigned Y_W     = 2,
  parameter int unsigned NDISP   = 2,
  parameter int unsigned STK_D   = 2,
  localparam int unsigned TS_W   = ts_w(NDISP),
  localparam int unsigned AW     = addr_w(STATE_W, NDISP, Y_W),
  localparam int unsigned CW     = word_w(STATE_W, NDISP),
  localparam int unsigned LW     = $clog2(STK_D + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [Y_W-1:0]     y_i,
  input  logic               cfg_we_i,
  input  logic               cfg_sel_i,
  input  logic [AW-1:0]      cfg_addr_i,
  input  logic [CW-1:0]      cfg_data_i,
  output logic [STATE_W-1:0] state_o,
  output logic [2:0]         op_o,
  output logic [LW-1:0]      stk_lvl_o,
  output logic               err_o
);

  localparam int unsigned DW = TS_W + Y_W;
  localparam int unsigned OpLsb = op_lsb(STATE_W, NDISP);
  localparam int unsigned TselLsb = tsel_lsb(STATE_W);

  // Sized to the full state space so any state indexes it; only words below DEPTH are written.
  logic [CW-1:0]      urom_q [2**STATE_W];
  logic [STATE_W-1:0] disp_q [2**DW];

  logic [STATE_W-1:0] state_q, state_d, nxt, inc, tgt, stk_top;
  logic               err_q, err_d, fault, push, pop, stk_full, stk_empty;
  logic [CW-1:0]      word;
  logic [2:0]         op;
  logic [TS_W-1:0]    tsel;
  logic               tsel_ok;
  logic [DW-1:0]      didx;
  logic               unused_cfg_addr;

  assign unused_cfg_addr = ^cfg_addr_i;

  always_ff @(posedge clk) begin
    if (cfg_we_i) begin
      if (cfg_sel_i) begin
        disp_q[cfg_addr_i[DW-1:0]] <= cfg_data_i[STATE_W-1:0];
      end else if (32'(cfg_addr_i[STATE_W-1:0]) < DEPTH) begin
        urom_q[cfg_addr_i[STATE_W-1:0]] <= cfg_data_i;
      end
    end
  end

  assign word    = urom_q[state_q];
  assign op      = word[OpLsb +: 3];
  assign tsel    = word[TselLsb +: TS_W];
  assign tgt     = word[TGT_LSB +: STATE_W];
  assign inc     = state_q + STATE_W'(1);
  assign tsel_ok = (32'(tsel) < NDISP);
  assign didx    = tsel_ok ? {tsel, y_i} : {TS_W'(0), y_i};

  always_comb begin
    nxt   = '0;
    push  = 1'b0;
    pop   = 1'b0;
    fault = 1'b0;
    unique case (op)
      OP_SEQ:  nxt = inc;
      OP_DISP: begin
        nxt   = disp_q[didx];
        fault = !tsel_ok;
      end
      OP_JMP:  nxt = tgt;
      OP_HOLD: nxt = (y_i != '0) ? state_q : inc;
      OP_ZERO: nxt = '0;
      OP_CALL: begin
        push  = 1'b1;
        fault = stk_full;
        nxt   = tgt;
      end
      OP_RET: begin
        if (stk_empty) begin
          fault = 1'b1;
        end else begin
          pop = 1'b1;
          nxt = stk_top;
        end
      end
      OP_BRY:  nxt = (y_i == '0) ? tgt : inc;
    endcase
    if (32'(nxt) >= DEPTH) begin
      nxt   = '0;
      fault = 1'b1;
    end
    state_d = en_i ? nxt : state_q;
    err_d   = err_q | (en_i & fault);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  useq_stack #(
    .W (STATE_W),
    .D (STK_D)
  ) u_stack (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (en_i & push),
    .pop_i  (en_i & pop),
    .data_i (inc),
    .top_o  (stk_top),
    .lvl_o  (stk_lvl_o),
    .ovf_o  (stk_full),
    .unf_o  (stk_empty)
  );

  assign state_o = state_q;
  assign op_o    = op;
  assign err_o   = err_q;

endmodule

// File: tb/tb_useq_fsm.sv
// Self-checking bench for useq_fsm: vector table for the legacy program plus hand-written
// sequences for call/return, stack faults, range faults, HOLD and asynchronous reset.
module tb_useq_fsm;
  import useq_pkg::*;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned DEPTH   = 13;
  localparam int unsigned Y_W     = 2;
  localparam int unsigned NDISP   = 2;
  localparam int unsigned STK_D   = 2;
  localparam int unsigned TS_W    = ts_w(NDISP);
  localparam int unsigned AW      = addr_w(STATE_W, NDISP, Y_W);
  localparam int unsigned CW      = word_w(STATE_W, NDISP);
  localparam int unsigned LW      = $clog2(STK_D + 1);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic [Y_W-1:0]     y = '0;
  logic               cfg_we = 1'b0;
  logic               cfg_sel = 1'b0;
  logic [AW-1:0]      cfg_addr = '0;
  logic [CW-1:0]      cfg_data = '0;
  logic [STATE_W-1:0] state;
  logic [2:0]         op;
  logic [LW-1:0]      stk_lvl;
  logic               err;

  useq_fsm #(
    .STATE_W (STATE_W),
    .DEPTH   (DEPTH),
    .Y_W     (Y_W),
    .NDISP   (NDISP),
    .STK_D   (STK_D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en),
    .y_i        (y),
    .cfg_we_i   (cfg_we),
    .cfg_sel_i  (cfg_sel),
    .cfg_addr_i (cfg_addr),
    .cfg_data_i (cfg_data),
    .state_o    (state),
    .op_o       (op),
    .stk_lvl_o  (stk_lvl),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [STATE_W-1:0] st;
    logic [LW-1:0]      lvl;
    logic               er;
    string              tag;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic               e;
    logic [Y_W-1:0]     yy;
    logic [STATE_W-1:0] st;
    logic [2:0]         op;
  } vec_t;

  vec_t vt [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expectation is queued when the stimulus is driven and retired after the edge it predicts.
  task automatic step(input logic e, input logic [Y_W-1:0] yy, input logic [STATE_W-1:0] st,
                      input logic [LW-1:0] lvl, input logic er, input string tag);
    exp_t x;
    @(negedge clk);
    en = e;
    y  = yy;
    x.st = st; x.lvl = lvl; x.er = er; x.tag = tag;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check({x.tag, " state"}, 32'(state), 32'(x.st));
    check({x.tag, " lvl"}, 32'(stk_lvl), 32'(x.lvl));
    check({x.tag, " err"}, 32'(err), 32'(x.er));
  endtask

  task automatic wr_word(input int a, input logic [2:0] o, input logic [TS_W-1:0] t,
                         input logic [STATE_W-1:0] tg);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = AW'(a); cfg_data = {o, t, tg};
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic wr_disp(input logic [TS_W-1:0] t, input logic [Y_W-1:0] yi,
                         input logic [STATE_W-1:0] tg);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = AW'({t, yi}); cfg_data = CW'(tg);
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic load_legacy();
    for (int i = 0; i < 3; i++) wr_word(i, OP_SEQ, 1'b0, 4'd0);
    wr_word(3, OP_DISP, 1'b0, 4'd0);
    wr_word(4, OP_JMP, 1'b0, 4'd7);
    wr_word(5, OP_JMP, 1'b0, 4'd7);
    for (int i = 6; i < 10; i++) wr_word(i, OP_SEQ, 1'b0, 4'd0);
    wr_word(10, OP_DISP, 1'b1, 4'd0);
    wr_word(11, OP_ZERO, 1'b0, 4'd0);
    wr_word(12, OP_ZERO, 1'b0, 4'd0);
    wr_disp(1'b0, 2'd0, 4'd4);  wr_disp(1'b0, 2'd1, 4'd5);
    wr_disp(1'b0, 2'd2, 4'd6);  wr_disp(1'b0, 2'd3, 4'd6);
    wr_disp(1'b1, 2'd0, 4'd11); wr_disp(1'b1, 2'd1, 4'd12);
    wr_disp(1'b1, 2'd2, 4'd12); wr_disp(1'b1, 2'd3, 4'd12);
  endtask

  // Asserted mid-cycle so the state check lands before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    check({tag, " rst state"}, 32'(state), 32'd0);
    check({tag, " rst lvl"}, 32'(stk_lvl), 32'd0);
    check({tag, " rst err"}, 32'(err), 32'd0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{1'b1, 2'd0, 4'd1,  OP_SEQ};
    vt[1]  = '{1'b1, 2'd0, 4'd2,  OP_SEQ};
    vt[2]  = '{1'b1, 2'd0, 4'd3,  OP_DISP};
    vt[3]  = '{1'b1, 2'd1, 4'd5,  OP_JMP};
    vt[4]  = '{1'b1, 2'd0, 4'd7,  OP_SEQ};
    vt[5]  = '{1'b1, 2'd3, 4'd8,  OP_SEQ};
    vt[6]  = '{1'b1, 2'd0, 4'd9,  OP_SEQ};
    vt[7]  = '{1'b1, 2'd0, 4'd10, OP_DISP};
    vt[8]  = '{1'b1, 2'd0, 4'd11, OP_ZERO};
    vt[9]  = '{1'b1, 2'd0, 4'd0,  OP_SEQ};
    vt[10] = '{1'b1, 2'd0, 4'd1,  OP_SEQ};
    vt[11] = '{1'b1, 2'd0, 4'd2,  OP_SEQ};
    vt[12] = '{1'b0, 2'd0, 4'd2,  OP_SEQ};
    vt[13] = '{1'b0, 2'd3, 4'd2,  OP_SEQ};
    vt[14] = '{1'b0, 2'd1, 4'd2,  OP_SEQ};
    vt[15] = '{1'b1, 2'd2, 4'd3,  OP_DISP};
    vt[16] = '{1'b1, 2'd2, 4'd6,  OP_SEQ};
    vt[17] = '{1'b1, 2'd0, 4'd7,  OP_SEQ};
    vt[18] = '{1'b1, 2'd0, 4'd8,  OP_SEQ};
    vt[19] = '{1'b1, 2'd0, 4'd9,  OP_SEQ};
    vt[20] = '{1'b1, 2'd0, 4'd10, OP_DISP};
    vt[21] = '{1'b1, 2'd2, 4'd12, OP_ZERO};
    vt[22] = '{1'b1, 2'd0, 4'd0,  OP_SEQ};

    repeat (2) @(posedge clk);
    do_reset("init");
    load_legacy();

    for (int i = 0; i < 23; i++) begin
      step(vt[i].e, vt[i].yy, vt[i].st, '0, 1'b0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d op", i), 32'(op), 32'(vt[i].op));
    end

    // Write to word 0 in the same cycle as leaving state 0: old SEQ wins, JMP 9 lands later.
    do_reset("wrx");
    @(negedge clk);
    en = 1'b1; y = '0;
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = {OP_JMP, 1'b0, 4'd9};
    @(posedge clk);
    #1 cfg_we = 1'b0;
    check("wrx pre-write", 32'(state), 32'd1);
    do_reset("wrx2");
    step(1'b1, 2'd0, 4'd9, 2'd0, 1'b0, "wrx post-write");

    do_reset("call");
    load_legacy();
    wr_word(1, OP_CALL, 1'b0, 4'd8);
    wr_word(8, OP_RET, 1'b0, 4'd0);
    step(1'b1, 2'd0, 4'd1, 2'd0, 1'b0, "call s1");
    step(1'b1, 2'd0, 4'd8, 2'd1, 1'b0, "call s8");
    step(1'b1, 2'd0, 4'd2, 2'd0, 1'b0, "ret s2");

    do_reset("ovf");
    load_legacy();
    wr_word(1, OP_CALL, 1'b0, 4'd5);
    wr_word(5, OP_CALL, 1'b0, 4'd7);
    wr_word(7, OP_CALL, 1'b0, 4'd9);
    wr_word(9, OP_RET, 1'b0, 4'd0);
    step(1'b1, 2'd0, 4'd1, 2'd0, 1'b0, "ovf s1");
    step(1'b1, 2'd0, 4'd5, 2'd1, 1'b0, "ovf s5");
    step(1'b1, 2'd0, 4'd7, 2'd2, 1'b0, "ovf s7");
    step(1'b1, 2'd0, 4'd9, 2'd2, 1'b1, "ovf full");
    step(1'b1, 2'd0, 4'd6, 2'd1, 1'b1, "ovf ret");

    do_reset("unf");
    load_legacy();
    wr_word(2, OP_RET, 1'b0, 4'd0);
    step(1'b1, 2'd0, 4'd1, 2'd0, 1'b0, "unf s1");
    step(1'b1, 2'd0, 4'd2, 2'd0, 1'b0, "unf s2");
    step(1'b1, 2'd0, 4'd0, 2'd0, 1'b1, "unf ret");
    step(1'b1, 2'd0, 4'd1, 2'd0, 1'b1, "unf sticky");

    do_reset("rng");
    load_legacy();
    wr_word(0, OP_JMP, 1'b0, 4'd11);
    wr_word(11, OP_SEQ, 1'b0, 4'd0);
    wr_word(12, OP_SEQ, 1'b0, 4'd0);
    step(1'b1, 2'd0, 4'd11, 2'd0, 1'b0, "rng s11");
    step(1'b1, 2'd0, 4'd12, 2'd0, 1'b0, "rng s12");
    step(1'b1, 2'd0, 4'd0, 2'd0, 1'b1, "rng wrap");
    step(1'b0, 2'd0, 4'd0, 2'd0, 1'b1, "rng en0");

    do_reset("bry");
    load_legacy();
    wr_word(1, OP_BRY, 1'b0, 4'd9);
    wr_word(2, OP_BRY, 1'b0, 4'd9);
    step(1'b1, 2'd0, 4'd1, 2'd0, 1'b0, "bry s1");
    step(1'b1, 2'd1, 4'd2, 2'd0, 1'b0, "bry y!=0");
    step(1'b1, 2'd0, 4'd9, 2'd0, 1'b0, "bry y==0");

    do_reset("hold");
    load_legacy();
    wr_word(4, OP_HOLD, 1'b0, 4'd0);
    wr_word(2, OP_CALL, 1'b0, 4'd3);
    step(1'b1, 2'd0, 4'd1, 2'd0, 1'b0, "hold s1");
    step(1'b1, 2'd0, 4'd2, 2'd0, 1'b0, "hold s2");
    step(1'b1, 2'd0, 4'd3, 2'd1, 1'b0, "hold s3");
    step(1'b1, 2'd0, 4'd4, 2'd1, 1'b0, "hold s4");
    check("hold op", 32'(op), 32'(OP_HOLD));
    for (int i = 0; i < 5; i++) step(1'b1, 2'd3, 4'd4, 2'd1, 1'b0, $sformatf("hold sit%0d", i));
    step(1'b1, 2'd0, 4'd5, 2'd1, 1'b0, "hold exit");

    do_reset("hold2");
    step(1'b1, 2'd0, 4'd1, 2'd0, 1'b0, "hold2 s1");
    step(1'b1, 2'd0, 4'd2, 2'd0, 1'b0, "hold2 s2");
    step(1'b1, 2'd0, 4'd3, 2'd1, 1'b0, "hold2 s3");
    step(1'b1, 2'd0, 4'd4, 2'd1, 1'b0, "hold2 s4");
    step(1'b1, 2'd3, 4'd4, 2'd1, 1'b0, "hold2 sit");
    do_reset("midhold");
    step(1'b1, 2'd0, 4'd1, 2'd0, 1'b0, "after s1");
    step(1'b1, 2'd0, 4'd2, 2'd0, 1'b0, "after s2");
    step(1'b1, 2'd0, 4'd3, 2'd1, 1'b0, "after s3");
    step(1'b1, 2'd0, 4'd4, 2'd1, 1'b0, "after s4");
    step(1'b1, 2'd3, 4'd4, 2'd1, 1'b0, "after sit");
    step(1'b1, 2'd0, 4'd5, 2'd1, 1'b0, "after exit");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
